seq_shift_unit: RTL

- Parametrised, multi-mode sequential shifter; next generation of the 5-bit load/left/right shift register.
- Accepts an operand, shift amount and operation over a valid/ready handshake, then shifts one bit position per clock.
- Returns the result and the last bit shifted out over a second valid/ready handshake.
- Sits between the datapath register file and the ALU result mux.

---
 rtl/shift_unit_pkg.sv | 17 +
 rtl/shift_step.sv | 46 ++++
 rtl/seq_shift_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/shift_unit_pkg.sv
// Shared definitions for the sequential shifter.
// Op codes and FSM state encoding.
package shift_unit_pkg;

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step.
// Purely combinational; one position per call.
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] data_nxt,
  output logic             carry_nxt
);

  // one-position move and the bit that falls off
  always_comb begin
    data_nxt  = data;
    carry_nxt = 1'b0;
    unique case (1'b1)
      (op == OP_LSL): begin
        data_nxt  = {data[WIDTH-2:0], 1'b0};
        carry_nxt = data[WIDTH-1];
      end
      (op == OP_LSR): begin
        data_nxt  = {1'b0, data[WIDTH-1:1]};
        carry_nxt = data[0];
      end
      (op == OP_ASR): begin
        data_nxt  = {data[WIDTH-1], data[WIDTH-1:1]};
        carry_nxt = data[0];
      end
      (op == OP_ROL): begin
        data_nxt  = {data[WIDTH-2:0], data[WIDTH-1]};
        carry_nxt = data[WIDTH-1];
      end
      (op == OP_ROR): begin
        data_nxt  = {data[0], data[WIDTH-1:1]};
        carry_nxt = data[0];
      end
      default: begin
        data_nxt  = data;
        carry_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-mode sequential shifter, one bit per clock.
// Request and result both use valid/ready.
module seq_shift_unit
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_err,
  output logic             busy
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] cnt_q;
  logic             carry_q;
  logic             err_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;
  logic             accept;
  logic             bad_op;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = !in_ready;
  assign accept    = in_valid && in_ready;
  assign bad_op    = (in_op > OP_ROR);

  assign out_data  = out_valid ? data_q : '0;
  assign out_carry = out_valid && carry_q;
  assign out_err   = out_valid && err_q;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .data     (data_q),
    .op       (op_q),
    .data_nxt (step_data),
    .carry_nxt(step_carry)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next-state: nothing to shift skips straight to DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bad_op || in_amt == '0) state_d = ST_DONE;
          else                        state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == AMT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath: capture on accept, step while shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            data_q  <= in_data;
            op_q    <= in_op;
            cnt_q   <= in_amt;
            carry_q <= 1'b0;
            err_q   <= bad_op;
          end
        end
        ST_SHIFT: begin
          data_q  <= step_data;
          carry_q <= step_carry;
          cnt_q   <= cnt_q - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
